// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the PC and issues word-aligned requests to instruction memory. Returned
// words are queued together with the PC they were fetched from, and the head is
// presented to decode with a valid/stall handshake. A redirect flushes the queue
// and marks every request still in flight as stale. Stale responses are counted
// down and dropped as they return.
//
// Ports:
//   clk, rst                    core clock, async active-low reset
//   imem_req_o / imem_addr_o    fetch request and word address
//   imem_gnt_i                  request accepted (req && gnt)
//   imem_rvalid_i/imem_rdata_i  in-order response word
//   redirect_i / redirect_pc_i  fetch path change (low two bits ignored)
//   stall_i                     decode holds the head entry
//   instr_o / pc_o              head word and its PC (NOP_INSTR / 0 when empty)
//   instr_valid_o               head entry valid
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [31:0]            pc;
  cnt_t                   live, cnt, discard_cnt, discard_nxt;
  logic [AW-1:0]          wr_ptr, rd_ptr, tag_wr, tag_rd;
  logic [DEPTH-1:0][31:0] buf_instr, buf_pc, tag_pc;
  logic [CW+1:0]          used;
  logic                   hs, rv_keep, rv_drop, pop;

  // Credits: every slot is either queued, in flight, or in flight and stale.
  assign used          = {2'b00, live} + {2'b00, cnt} + {2'b00, discard_cnt};
  assign imem_req_o    = (state != BOOT) && (used < (CW+2)'(DEPTH)) && !redirect_i;
  assign imem_addr_o   = pc;
  assign hs            = imem_req_o && imem_gnt_i;
  assign rv_drop       = imem_rvalid_i && (discard_cnt != '0);
  assign rv_keep       = imem_rvalid_i && (discard_cnt == '0);
  assign instr_valid_o = (cnt != '0);
  assign pop           = instr_valid_o && !stall_i && !redirect_i;
  assign instr_o       = instr_valid_o ? buf_instr[rd_ptr] : NOP_INSTR;
  assign pc_o          = instr_valid_o ? buf_pc[rd_ptr] : 32'h0;

  // On redirect every live request turns stale, except one returning this
  // very cycle (its word is dropped here instead of later).
  always_comb begin
    discard_nxt = discard_cnt;
    if (redirect_i)
      discard_nxt = discard_cnt + live - cnt_t'(rv_keep) - cnt_t'(rv_drop);
    else if (rv_drop)
      discard_nxt = discard_cnt - cnt_t'(1);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (redirect_i && discard_nxt != '0) state_nxt = DRAIN;
      DRAIN:   if (discard_nxt == '0) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      live        <= '0;
      cnt         <= '0;
      discard_cnt <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      state       <= state_nxt;
      discard_cnt <= discard_nxt;
      if (redirect_i) begin
        pc     <= {redirect_pc_i[31:2], 2'b00};
        live   <= '0;
        cnt    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        tag_wr <= '0;
        tag_rd <= '0;
      end else begin
        if (hs) begin
          pc     <= pc + 32'd4;
          tag_wr <= tag_wr + AW'(1);
        end
        if (rv_keep) begin
          wr_ptr <= wr_ptr + AW'(1);
          tag_rd <= tag_rd + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        live <= live + cnt_t'(hs) - cnt_t'(rv_keep);
        cnt  <= cnt + cnt_t'(rv_keep) - cnt_t'(pop);
      end
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (hs) tag_pc[tag_wr] <= pc;
    if (rv_keep && !redirect_i) begin
      buf_instr[wr_ptr] <= imem_rdata_i;
      buf_pc[wr_ptr]    <= tag_pc[tag_rd];
    end
  end

  // Protocol checks: the credit rule keeps the queue from overflowing, and
  // memory never answers a request that was not issued.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(rv_keep && !redirect_i && cnt == CW'(DEPTH) && !pop));
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rvalid_i && live == '0 && discard_cnt == '0));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit. The bench plays instruction
// memory (in-order responses, random grant/latency). Its reference model tags
// each issued request with a fetch-path epoch; responses from an older epoch
// are stale, current ones join a queue that decode must see in order.
module tb_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        redirect_i, stall_i, instr_valid_o;
  logic [31:0] redirect_pc_i, instr_o, pc_o;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .stall_i(stall_i),
    .instr_o(instr_o), .pc_o(pc_o), .instr_valid_o(instr_valid_o)
  );

  typedef struct { logic [31:0] addr; int epoch; int ready; } req_t;
  req_t        infl[$];    // issued, not yet answered (any epoch)
  logic [31:0] visq[$];    // PCs decode should see, in order
  logic [31:0] popped[$];  // DUT pc_o at each accepted instruction
  logic [31:0] m_pc;
  bit          boot;
  int          epoch, cyc, first_vld, dut_hs;
  int          gnt_pct, stall_pct, rv_pct, lat_min, lat_max;
  int          n_cmp, n_bad;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h0010_0093 + a;
  endfunction

  // One clock: drive at negedge, check 1ns later, advance the model.
  task automatic step(input bit redir, input logic [31:0] tgt);
    bit g, s, v, ereq, evld;
    logic [31:0] epc, einstr;
    req_t f, nf;
    int lat;
    @(negedge clk);
    g = int'($urandom_range(99)) < gnt_pct;
    s = int'($urandom_range(99)) < stall_pct;
    v = (infl.size() > 0) && (infl[0].ready <= cyc) && (int'($urandom_range(99)) < rv_pct);
    imem_gnt_i    = g;
    imem_rvalid_i = v;
    imem_rdata_i  = v ? word_of(infl[0].addr) : $urandom();
    redirect_i    = redir;
    redirect_pc_i = tgt;
    stall_i       = s;
    #1;
    ereq   = !boot && (infl.size() + visq.size() < DEPTH) && !redir;
    evld   = visq.size() != 0;
    epc    = evld ? visq[0] : 32'h0;
    einstr = evld ? word_of(visq[0]) : NOP;
    n_cmp += 5;
    if (imem_req_o !== ereq) begin
      n_bad++; $display("FAIL req cyc=%0d got=%0b exp=%0b", cyc, imem_req_o, ereq);
    end
    if (imem_addr_o !== m_pc) begin
      n_bad++; $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, imem_addr_o, m_pc);
    end
    if (instr_valid_o !== evld) begin
      n_bad++; $display("FAIL valid cyc=%0d got=%0b exp=%0b", cyc, instr_valid_o, evld);
    end
    if (pc_o !== epc) begin
      n_bad++; $display("FAIL pc cyc=%0d got=%h exp=%h", cyc, pc_o, epc);
    end
    if (instr_o !== einstr) begin
      n_bad++; $display("FAIL instr cyc=%0d got=%h exp=%h", cyc, instr_o, einstr);
    end
    if (instr_valid_o === 1'b1 && first_vld < 0) first_vld = cyc;
    if (imem_req_o === 1'b1 && g) dut_hs++;
    if (evld && !s && !redir) begin
      popped.push_back(pc_o);
      void'(visq.pop_front());
    end
    if (v) begin
      f = infl.pop_front();
      if (!redir && f.epoch == epoch) visq.push_back(f.addr);
    end
    if (ereq && g) begin
      lat = int'($urandom_range(lat_max, lat_min));
      nf.addr = m_pc; nf.epoch = epoch; nf.ready = cyc + lat;
      infl.push_back(nf);
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      visq.delete();
      epoch++;
      m_pc = {tgt[31:2], 2'b00};
    end
    boot = 1'b0;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
    redirect_i = 0; redirect_pc_i = '0; stall_i = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Released just after a rising edge, so the next cycle is the boot cycle.
  // Responses still owed from before reset are simply never sent.
  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    infl.delete(); visq.delete(); popped.delete();
    m_pc = RESET_PC; boot = 1'b1; epoch++; cyc = 0; first_vld = -1; dut_hs = 0;
  endtask

  task automatic set_knobs(input int g, input int s, input int rv, input int lmin, input int lmax);
    gnt_pct = g; stall_pct = s; rv_pct = rv; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp += 5;
    if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%0b exp=0", imem_req_o); end
    if (imem_addr_o !== RESET_PC) begin n_bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr_o, RESET_PC); end
    if (instr_o !== NOP) begin n_bad++; $display("FAIL reset_instr got=%h exp=%h", instr_o, NOP); end
    if (pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
    if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b exp=0", instr_valid_o); end
    release_reset();
  endtask

  task automatic test_stream();
    set_knobs(100, 0, 100, 1, 1);
    apply_reset(); release_reset();
    repeat (12) step(1'b0, 32'h0);
    n_cmp += 2;
    if (first_vld != 3) begin n_bad++; $display("FAIL stream_first_valid got=%0d exp=3", first_vld); end
    if (popped.size() < 3 || popped[0] !== 32'h0 || popped[1] !== 32'h4 || popped[2] !== 32'h8) begin
      n_bad++; $display("FAIL stream_order got_n=%0d exp first pcs 0,4,8", popped.size());
    end
  endtask

  task automatic test_backpressure();
    set_knobs(100, 100, 100, 1, 1);
    apply_reset(); release_reset();
    repeat (6) step(1'b0, 32'h0);
    n_cmp += 3;
    if (dut_hs != 2) begin n_bad++; $display("FAIL bp_handshakes got=%0d exp=2", dut_hs); end
    if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL bp_req_drop got=%0b exp=0", imem_req_o); end
    if (pc_o !== 32'h0 || instr_valid_o !== 1'b1) begin
      n_bad++; $display("FAIL bp_head got pc=%h v=%0b exp pc=0 v=1", pc_o, instr_valid_o);
    end
    stall_pct = 0;
    popped.delete();
    repeat (12) step(1'b0, 32'h0);
    n_cmp++;
    if (popped.size() < 4 || popped[0] !== 32'h0 || popped[1] !== 32'h4 ||
        popped[2] !== 32'h8 || popped[3] !== 32'hC) begin
      n_bad++; $display("FAIL bp_release_order got_n=%0d exp pcs 0,4,8,c", popped.size());
    end
  endtask

  task automatic test_redirect_inflight();
    int guard, base;
    set_knobs(100, 0, 100, 4, 4);
    apply_reset(); release_reset();
    guard = 0;
    while (!(infl.size() == 2 && infl[0].addr == 32'h8 && infl[1].addr == 32'hC &&
             infl[0].ready > cyc && infl[0].epoch == epoch) && guard < 60) begin
      step(1'b0, 32'h0);
      guard++;
    end
    n_cmp++;
    if (guard >= 60) begin n_bad++; $display("FAIL rdi_setup timeout got=%0d cycles exp<60", guard); end
    step(1'b1, 32'h100);
    base = popped.size();
    repeat (25) step(1'b0, 32'h0);
    n_cmp++;
    if (popped.size() <= base || popped[base] !== 32'h100) begin
      n_bad++; $display("FAIL rdi_first_pc got_n=%0d exp first pc 100", popped.size() - base);
    end
  endtask

  task automatic test_redirect_rvalid();
    int base, hits;
    set_knobs(100, 100, 100, 1, 1);
    apply_reset(); release_reset();
    repeat (3) step(1'b0, 32'h0);
    step(1'b1, 32'h40);
    n_cmp++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h0) begin
      n_bad++; $display("FAIL rdr_head got v=%0b pc=%h exp v=1 pc=0", instr_valid_o, pc_o);
    end
    step(1'b0, 32'h0);
    n_cmp++;
    if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL rdr_flush got=%0b exp=0", instr_valid_o); end
    stall_pct = 0;
    base = popped.size();
    repeat (15) step(1'b0, 32'h0);
    hits = 0;
    for (int i = base; i < popped.size(); i++) if (popped[i] === 32'h4) hits++;
    n_cmp += 2;
    if (hits != 0) begin n_bad++; $display("FAIL rdr_stale_seen got=%0d exp=0", hits); end
    if (popped.size() <= base || popped[base] !== 32'h40) begin
      n_bad++; $display("FAIL rdr_first_pc got_n=%0d exp first pc 40", popped.size() - base);
    end
  endtask

  task automatic test_delayed_gnt();
    int base;
    set_knobs(0, 0, 100, 1, 1);
    apply_reset(); release_reset();
    repeat (5) step(1'b0, 32'h0);
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL dg_hold got req=%0b addr=%h exp req=1 addr=0", imem_req_o, imem_addr_o);
    end
    step(1'b1, 32'h203);
    gnt_pct = 100;
    step(1'b0, 32'h0);
    n_cmp++;
    if (imem_addr_o !== 32'h200 || imem_req_o !== 1'b1) begin
      n_bad++; $display("FAIL dg_align got req=%0b addr=%h exp req=1 addr=200", imem_req_o, imem_addr_o);
    end
    base = popped.size();
    repeat (10) step(1'b0, 32'h0);
    n_cmp++;
    if (popped.size() <= base || popped[base] !== 32'h200) begin
      n_bad++; $display("FAIL dg_first_pc got_n=%0d exp first pc 200", popped.size() - base);
    end
  endtask

  task automatic test_async_reset();
    set_knobs(100, 0, 100, 4, 4);
    apply_reset(); release_reset();
    repeat (3) step(1'b0, 32'h0);
    step(1'b1, 32'h80);
    step(1'b0, 32'h0);
    #2 rst = 1'b0;
    #1;
    n_cmp += 5;
    if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL ar_req got=%0b exp=0", imem_req_o); end
    if (imem_addr_o !== RESET_PC) begin n_bad++; $display("FAIL ar_addr got=%h exp=%h", imem_addr_o, RESET_PC); end
    if (instr_o !== NOP) begin n_bad++; $display("FAIL ar_instr got=%h exp=%h", instr_o, NOP); end
    if (pc_o !== 32'h0) begin n_bad++; $display("FAIL ar_pc got=%h exp=0", pc_o); end
    if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL ar_valid got=%0b exp=0", instr_valid_o); end
    apply_reset(); release_reset();
    set_knobs(100, 0, 100, 1, 3);
    repeat (15) step(1'b0, 32'h0);
    n_cmp++;
    if (popped.size() == 0 || popped[0] !== RESET_PC) begin
      n_bad++; $display("FAIL ar_restart got_n=%0d exp first pc %h", popped.size(), RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    bit r;
    apply_reset(); release_reset();
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0)
        set_knobs(int'($urandom_range(100, 30)), int'($urandom_range(60, 0)),
                  int'($urandom_range(100, 40)), 1, int'($urandom_range(5, 1)));
      r = $urandom_range(99) < 3;
      tgt = $urandom();
      if ($urandom_range(3) == 0) tgt = {30'h3FFF_FFFD, tgt[1:0]};
      step(r, tgt);
    end
    n_cmp++;
    if (popped.size() < 50) begin n_bad++; $display("FAIL rnd_progress got=%0d exp>=50", popped.size()); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; epoch = 0; cyc = 0; first_vld = -1; dut_hs = 0;
    m_pc = RESET_PC; boot = 1'b1;
    set_knobs(100, 0, 100, 1, 1);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_rvalid();
    test_delayed_gnt();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
